// File: rtl/enc32x5_drain.sv
`default_nettype none
// ============================================================================
// Module      : dec5x32 / enc32x5_drain
// Description : dec5x32 is the register-file index decoder. It turns a 5-bit
//               index into a one-hot 32-bit word, gated by en.
//               enc32x5_drain is the matching sequential 32:5 encoder. It
//               accepts a pending mask, then emits the index of each set bit,
//               lowest first, with one index per valid/ready handshake.
//               Each bit is cleared as it is emitted.
// Ports (enc32x5_drain):
//   clk         in   clock; all state changes on posedge
//   reset_n     in   synchronous reset, active-low
//   load_valid  in   load_mask is valid
//   load_ready  out  a mask can be accepted: IDLE and not in reset
//   load_mask   in   mask to drain; bit i set means index i is emitted
//   out_valid   out  out_idx holds a valid index
//   out_ready   in   consumer accepts out_idx this cycle
//   out_idx     out  lowest pending index (registered)
//   out_last    out  out_valid and only one bit remains pending
//   done        out  one-cycle pulse after a mask has fully drained
//   busy        out  draining (SCAN state)
//   pending     out  bits not yet emitted (registered)
//   abort       in   discard the mask being drained; no done pulse
// Revision    : 1.0 - initial release
// ============================================================================

module dec5x32 #(
    parameter int N = 32,
    parameter int W = 5
) (
    input  logic         en,
    input  logic [W-1:0] idx,
    output logic [N-1:0] onehot
);
    for (genvar g = 0; g < N; g++) begin : g_bit
        assign onehot[g] = en && (idx == W'(g));
    end
endmodule

module enc32x5_drain #(
    parameter int N = 32,
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] load_mask,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         done,
    output logic         busy,
    output logic [N-1:0] pending,
    input  logic         abort
);
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [N-1:0]   r_pending, w_pending_nxt;
    logic [W-1:0]   r_idx, w_idx_nxt;
    logic           r_valid, w_valid_nxt;
    logic           r_done, w_done_nxt;

    logic [N-1:0]   w_idx_onehot;
    logic [N-1:0]   w_pending_clr;
    logic           w_handshake;

    // Lowest set bit wins. The loop runs from the top down, so lower bits
    // overwrite higher ones. A zero mask yields 0. That value is never
    // registered, because zero masks never reach out_idx.
    function automatic logic [W-1:0] ffs(input logic [N-1:0] m);
        logic [W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = i[W-1:0];
            end
        end
        return r;
    endfunction

    // The current index is decoded back to its one-hot pending bit. That bit
    // is cleared on a handshake.
    dec5x32 #(
        .N(N),
        .W(W)
    ) u_dec (
        .en     (1'b1),
        .idx    (r_idx),
        .onehot (w_idx_onehot)
    );

    assign w_pending_clr = r_pending & ~w_idx_onehot;
    assign w_handshake   = r_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_idx     <= w_idx_nxt;
            r_valid   <= w_valid_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_idx_nxt     = r_idx;
        w_valid_nxt   = r_valid;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_valid && load_ready) begin
                    if (|load_mask) begin
                        w_pending_nxt = load_mask;
                        w_idx_nxt     = ffs(load_mask);
                        w_valid_nxt   = 1'b1;
                        w_state_nxt   = ST_SCAN;
                    end else begin
                        // An empty mask completes immediately.
                        w_done_nxt    = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    // Abort beats a same-cycle handshake. The index on offer
                    // is dropped, not consumed.
                    w_pending_nxt = '0;
                    w_valid_nxt   = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end else if (w_handshake) begin
                    w_pending_nxt = w_pending_clr;
                    if (|w_pending_clr) begin
                        w_idx_nxt   = ffs(w_pending_clr);
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_pending_nxt = '0;
                w_valid_nxt   = 1'b0;
            end
        endcase
    end

    assign load_ready = (r_state == ST_IDLE) && reset_n;
    assign out_valid  = r_valid;
    assign out_idx    = r_idx;
    assign pending    = r_pending;
    assign done       = r_done;
    assign busy       = (r_state == ST_SCAN);
    // At most one bit set: clearing the lowest set bit leaves zero.
    assign out_last   = r_valid && ((r_pending & (r_pending - {{(N-1){1'b0}}, 1'b1})) == '0);

endmodule
`default_nettype wire

// File: tb/tb_enc32x5_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_enc32x5_drain
// Description : Directed vector bench for enc32x5_drain. Each table row
//               holds the inputs for one clock edge and the outputs expected
//               just after that edge. A few hand-written sequences follow
//               the table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enc32x5_drain;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_mask;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        done;
    logic        busy;
    logic [31:0] pending;
    logic        abort;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    enc32x5_drain dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_mask  (load_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .done       (done),
        .busy       (busy),
        .pending    (pending),
        .abort      (abort)
    );

    typedef struct {
        logic        rn;
        logic        lv;
        logic [31:0] mask;
        logic        rdy;
        logic        ab;
        logic        ov;
        logic [4:0]  idx;
        logic        last;
        logic        dn;
        logic        bsy;
        logic        lr;
        logic [31:0] pend;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rn, input logic lv, input logic [31:0] m,
                       input logic rdy, input logic ab, input logic ov,
                       input logic [4:0] idx, input logic last, input logic dn,
                       input logic bsy, input logic lr, input logic [31:0] pend);
        vec_t v;
        v.rn = rn;  v.lv = lv;   v.mask = m;   v.rdy = rdy; v.ab = ab;
        v.ov = ov;  v.idx = idx; v.last = last; v.dn = dn;  v.bsy = bsy;
        v.lr = lr;  v.pend = pend;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rn, input logic lv, input logic [31:0] m,
                         input logic rdy, input logic ab);
        reset_n = rn; load_valid = lv; load_mask = m; out_ready = rdy; abort = ab;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    int          cyc;
    int          nidx;
    logic [4:0]  seen [0:3];

    initial begin
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

        //   rn lv mask          rdy ab | ov idx last dn bsy lr pend
        // Reset held with a load offered
        add(0, 1, 32'hFFFF_FFFF, 0, 0,   0, 0,  0,   0, 0,  0, 32'h0);
        add(0, 1, 32'hFFFF_FFFF, 0, 0,   0, 0,  0,   0, 0,  0, 32'h0);
        add(1, 0, 32'h0,         0, 0,   0, 0,  0,   0, 0,  1, 32'h0);
        // Drain 0x80000421 at full rate
        add(1, 1, 32'h8000_0421, 1, 0,   1, 0,  0,   0, 1,  0, 32'h8000_0421);
        add(1, 0, 32'h0,         1, 0,   1, 5,  0,   0, 1,  0, 32'h8000_0420);
        add(1, 0, 32'h0,         1, 0,   1, 10, 0,   0, 1,  0, 32'h8000_0400);
        add(1, 0, 32'h0,         1, 0,   1, 31, 1,   0, 1,  0, 32'h8000_0000);
        add(1, 0, 32'h0,         1, 0,   0, 0,  0,   1, 0,  1, 32'h0);
        add(1, 0, 32'h0,         0, 0,   0, 0,  0,   0, 0,  1, 32'h0);
        // Backpressure; loads offered during the drain are ignored
        add(1, 1, 32'h0000_0006, 0, 0,   1, 1,  0,   0, 1,  0, 32'h6);
        add(1, 0, 32'h0,         0, 0,   1, 1,  0,   0, 1,  0, 32'h6);
        add(1, 1, 32'hFFFF_FFFF, 0, 0,   1, 1,  0,   0, 1,  0, 32'h6);
        add(1, 0, 32'h0,         0, 0,   1, 1,  0,   0, 1,  0, 32'h6);
        add(1, 1, 32'h0000_0001, 1, 0,   1, 2,  1,   0, 1,  0, 32'h4);
        add(1, 0, 32'h0,         1, 0,   0, 0,  0,   1, 0,  1, 32'h0);
        add(1, 0, 32'h0,         0, 0,   0, 0,  0,   0, 0,  1, 32'h0);
        // Zero mask, then an immediate reload
        add(1, 1, 32'h0,         0, 0,   0, 0,  0,   1, 0,  1, 32'h0);
        add(1, 1, 32'h0000_0010, 0, 0,   1, 4,  1,   0, 1,  0, 32'h10);
        add(1, 0, 32'h0,         1, 0,   0, 0,  0,   1, 0,  1, 32'h0);
        // Abort mid-drain, coinciding with a handshake at idx 3
        add(1, 1, 32'hFFFF_FFFF, 0, 0,   1, 0,  0,   0, 1,  0, 32'hFFFF_FFFF);
        add(1, 0, 32'h0,         1, 0,   1, 1,  0,   0, 1,  0, 32'hFFFF_FFFE);
        add(1, 0, 32'h0,         1, 0,   1, 2,  0,   0, 1,  0, 32'hFFFF_FFFC);
        add(1, 0, 32'h0,         1, 0,   1, 3,  0,   0, 1,  0, 32'hFFFF_FFF8);
        add(1, 0, 32'h0,         1, 1,   0, 0,  0,   0, 0,  1, 32'h0);
        add(1, 0, 32'h0,         0, 0,   0, 0,  0,   0, 0,  1, 32'h0);
        add(1, 1, 32'h0000_0010, 0, 0,   1, 4,  1,   0, 1,  0, 32'h10);
        add(1, 0, 32'h0,         1, 0,   0, 0,  0,   1, 0,  1, 32'h0);
        add(1, 0, 32'h0,         0, 0,   0, 0,  0,   0, 0,  1, 32'h0);
        // Reset mid-drain after idx 12 is accepted
        add(1, 1, 32'h0000_F000, 0, 0,   1, 12, 0,   0, 1,  0, 32'hF000);
        add(1, 0, 32'h0,         1, 0,   1, 13, 0,   0, 1,  0, 32'hE000);
        add(0, 0, 32'h0,         1, 0,   0, 0,  0,   0, 0,  0, 32'h0);
        add(1, 0, 32'h0,         1, 0,   0, 0,  0,   0, 0,  1, 32'h0);
        // Abort is ignored in IDLE, so the load still goes ahead
        add(1, 1, 32'h0000_0003, 0, 1,   1, 0,  0,   0, 1,  0, 32'h3);
        add(1, 0, 32'h0,         1, 0,   1, 1,  1,   0, 1,  0, 32'h2);
        add(1, 0, 32'h0,         1, 0,   0, 0,  0,   1, 0,  1, 32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].rn, vecs[i].lv, vecs[i].mask, vecs[i].rdy, vecs[i].ab);
            step();
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            if (vecs[i].ov || !vecs[i].rn)
                check($sformatf("v%0d out_idx", i), 32'(out_idx), 32'(vecs[i].idx));
            check($sformatf("v%0d out_last", i), 32'(out_last), 32'(vecs[i].last));
            check($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].dn));
            check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
            check($sformatf("v%0d load_ready", i), 32'(load_ready), 32'(vecs[i].lr));
            check($sformatf("v%0d pending", i), pending, vecs[i].pend);
        end

        // Drain 0x81 with out_ready held high. With k=2 set bits, done must
        // appear on the third observed cycle after the load edge, and never
        // together with out_valid.
        drive(1'b1, 1'b1, 32'h0000_0081, 1'b1, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc  = 1;
        nidx = 0;
        while (!done && cyc < 20) begin
            if (out_valid && done)
                check("done_with_valid", 32'(done && out_valid), 32'd0);
            if (out_valid && nidx < 4) begin
                seen[nidx] = out_idx;
                nidx++;
            end
            step();
            cyc++;
        end
        check("drain_done_cycle", 32'(cyc), 32'd3);
        check("drain_count", 32'(nidx), 32'd2);
        check("drain_idx0", 32'(seen[0]), 32'd0);
        check("drain_idx1", 32'(seen[1]), 32'd7);
        check("drain_valid_at_done", 32'(out_valid), 32'd0);
        step();
        check("done_one_cycle", 32'(done), 32'd0);

        // Back-to-back load right after a drain finishes, with single bit 31
        drive(1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("top_bit_idx", 32'(out_idx), 32'd31);
        check("top_bit_last", 32'(out_last), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/enc32x5_drain.md
Name: enc32x5_drain

Overview:
- Sequential 32:5 encoder; the inverse of the register-file 5:32 write decoder.
- Accepts a 32-bit pending mask (e.g. register-valid/scoreboard bits), then emits the 5-bit index of each set bit, lowest first, one per valid/ready handshake, clearing each bit as it is emitted.
- Used to walk multi-register bitmasks (scoreboard flush, multi-register writeback/restore) one register number at a time into decoder-driven logic.

Parameters:
N  32  mask width; fixed, must equal 2**W
W  5   index width

Ports:
clk         input   1   clock, all state updates on posedge
reset_n     input   1   synchronous reset, active-low
load_valid  input   1   load_mask is valid
load_ready  output  1   block can accept a mask; equals (state==IDLE) && reset_n
load_mask   input   32  mask to drain; bit i set means index i is to be emitted
out_valid   output  1   out_idx holds a valid index
out_ready   input   1   consumer accepts out_idx this cycle
out_idx     output  5   index of the lowest set bit still pending (registered)
out_last    output  1   out_valid and this is the only pending bit
done        output  1   one-cycle pulse when a mask has fully drained
busy        output  1   state==SCAN
pending     output  32  remaining bits, registered
abort       input   1   flush the current mask

Behaviour:
- Reset (reset_n low at a posedge): state IDLE; pending=0, out_idx=0, out_valid=0, done=0, busy=0; out_last=0.
  - Overrides every other input, including mid-drain.
  - load_ready=0 while reset_n is low.
- States: IDLE and SCAN.
- IDLE:
  - load accepted when load_valid && load_ready.
  - Non-zero mask: next cycle pending=load_mask, out_idx=ffs(load_mask), out_valid=1, state SCAN. First index is visible 1 cycle after the load.
  - Zero mask: stays IDLE; done=1 for exactly the next cycle; out_valid stays 0.
  - abort is ignored in IDLE.
- SCAN:
  - out_valid=1 continuously.
  - Handshake = out_valid && out_ready. On a handshake:
    - pending' = pending & ~(1<<out_idx).
    - If pending' is non-zero: out_idx' = ffs(pending'), with no bubble, so back-to-back handshakes give one index per cycle.
    - If pending' is zero: out_valid'=0, state IDLE, done=1 for exactly that next cycle.
  - No handshake: out_idx, pending and out_valid are held stable.
  - abort=1: next cycle pending=0, out_valid=0, state IDLE, no done pulse. Abort has priority over a same-cycle handshake, and that index counts as not consumed.
  - load_valid is ignored in SCAN (load_ready=0).
- ffs() is a priority encoder: lowest set bit wins, bit 0 has highest priority. Result is undefined for zero, but it is never registered into out_idx for a zero mask.
- out_last is combinational: out_valid && (pending & (pending-1))==0.
- busy = (state==SCAN).
- done is never asserted in the same cycle as out_valid.
- Total drain of a mask with k set bits and out_ready held high: k+1 cycles from load to done; done is high in cycle load+k+1.
- Inside the block, out_idx must round-trip through dec5x32 (decode with en=1) to the one-hot bit of the set bit it names.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with load_valid=1, load_mask=0xFFFFFFFF -> out_valid=0, pending=0, out_idx=0, busy=0, done=0, load_ready=0; after release load_ready=1.
- Load 0x80000421 at T, out_ready=1 -> out_idx=0,5,10,31 in cycles T+1..T+4; out_last=1 only at T+4; done=1 at T+5; load_ready=1 at T+5.
- Backpressure:
  - Load 0x00000006 with out_ready=0 for 3 cycles -> out_idx=1, out_valid=1, pending=0x6 held stable.
  - Then out_ready=1 -> idx 1 then 2, done one cycle after idx 2.
  - load_valid pulsed during the drain is ignored.
- Zero mask: load 0x00000000 -> out_valid never asserts; done=1 one cycle after the load; busy stays 0; next load accepted immediately.
- Abort mid-drain:
  - Load 0xFFFFFFFF and handshake idx 0,1,2; then assert abort alongside out_ready at idx 3 -> next cycle out_valid=0, pending=0, busy=0, no done pulse.
  - A new load of 0x00000010 then yields idx 4.
- Reset mid-drain: load 0x0000F000 and accept idx 12; drop reset_n for 1 cycle -> all outputs reset values at next edge; idx 13 is never emitted.
